// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state, owner and request types for the data-memory arbiter
package dmem_arb_pkg;
  localparam int REQ_AW = 64;
  localparam int REQ_DW = 64;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;
  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: CPU-first grant decision with an EXT anti-starvation streak counter
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic cpu_req,
  input  logic ext_req,
  output logic grant,
  output logic owner
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak;
  always_comb begin
    grant = idle & (cpu_req | ext_req);
    owner = (ext_req & (~cpu_req | streak == SW'(STARVE_MAX))) ? OWN_EXT : OWN_CPU;
  end
  always_ff @(posedge clk)
    if (reset) streak <= '0;
    else if (idle) streak <= (~ext_req | owner == OWN_EXT) ? '0 : streak + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/EXT data-memory port arbiter with fixed-latency sequencing; DMEM_ARB_PERF_EN adds grant/stall counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       cpu_grant_cnt,
  output logic [31:0]       ext_grant_cnt,
  output logic [31:0]       stall_cycle_cnt
`endif
);
  localparam int LW = $clog2(MEM_LAT + 1);
  state_t state;
  logic owner;
  logic [LW-1:0] lat_cnt;
  req_t lat;
  req_t sel;
  logic gnt;
  logic gnt_own;
  dmem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk(clk),
    .reset(reset),
    .idle(state == IDLE),
    .cpu_req(cpu_req),
    .ext_req(ext_req),
    .grant(gnt),
    .owner(gnt_own)
  );
  always_comb begin
    sel = (gnt_own == OWN_EXT) ? req_t'{ext_we, REQ_AW'(ext_addr), REQ_DW'(ext_wdata)}
                               : req_t'{cpu_we, REQ_AW'(cpu_addr), REQ_DW'(cpu_wdata)};
    cpu_stall = cpu_req & ~cpu_ack;
    mem_addr = lat.addr[ADDR_W-1:0];
    mem_wdata = lat.wdata[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_cnt   <= '0;
      lat       <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      mem_we  <= 1'b0;
      if (state == IDLE) begin
        if (gnt) begin
          state   <= BUSY;
          owner   <= gnt_own;
          lat     <= sel;
          lat_cnt <= LW'(MEM_LAT - 1);
          mem_we  <= sel.we;
          mem_re  <= ~sel.we;
        end
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (lat_cnt == '0) begin
          state   <= RESP;
          lat     <= '0;
          mem_re  <= 1'b0;
          cpu_ack <= owner == OWN_CPU;
          ext_ack <= owner == OWN_EXT;
          if (!lat.we && owner == OWN_CPU) cpu_rdata <= mem_rdata;
          if (!lat.we && owner == OWN_EXT) ext_rdata <= mem_rdata;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_grant_cnt   <= '0;
      ext_grant_cnt   <= '0;
      stall_cycle_cnt <= '0;
    end else begin
      cpu_grant_cnt   <= cpu_grant_cnt + 32'(gnt && gnt_own == OWN_CPU);
      ext_grant_cnt   <= ext_grant_cnt + 32'(gnt && gnt_own == OWN_EXT);
      stall_cycle_cnt <= stall_cycle_cnt + 32'(cpu_stall);
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, corner sequences and randomized reference-model checks for dmem_arbiter
module tb_dmem_arbiter;
  localparam int LAT = 3;
  localparam int SMAX = 4;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFF8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
  logic cpu_ack, ext_ack, cpu_stall, mem_we, mem_re;
  logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic [63:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_grant_cnt, ext_grant_cnt, stall_cycle_cnt;
`endif
  int errs = 0;
  int checks = 0;
  logic [63:0] emem [logic [63:0]];
  logic [63:0] mmem [logic [63:0]];
  typedef struct {
    bit          ext;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [10];
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req),
    .ext_we(ext_we),
    .ext_addr(ext_addr),
    .ext_wdata(ext_wdata),
    .ext_ack(ext_ack),
    .ext_rdata(ext_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .cpu_grant_cnt(cpu_grant_cnt),
    .ext_grant_cnt(ext_grant_cnt),
    .stall_cycle_cnt(stall_cycle_cnt)
`endif
  );
  function automatic logic [63:0] dflt(input logic [63:0] a);
    return {a[31:0], ~a[31:0]} ^ 64'h5A5A_0000_0000_A5A5;
  endfunction
  always @(negedge clk) mem_rdata <= emem.exists(mem_addr) ? emem[mem_addr] : dflt(mem_addr);
  always @(posedge clk) if (mem_we) emem[mem_addr] = mem_wdata;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset(input bit sreq);
    @(negedge clk);
    reset = 1'b1;
    cpu_req = sreq;
    ext_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
    chk("rst_ext_ack", 64'(ext_ack), 64'(0));
    chk("rst_cpu_rdata", cpu_rdata, 64'(0));
    chk("rst_ext_rdata", ext_rdata, 64'(0));
    chk("rst_mem_addr", mem_addr, 64'(0));
    chk("rst_mem_wdata", mem_wdata, 64'(0));
    chk("rst_mem_we_re", 64'({mem_we, mem_re}), 64'(0));
    chk("rst_stall", 64'(cpu_stall), 64'(sreq));
`ifdef DMEM_ARB_PERF_EN
    chk("rst_cnts", 64'(cpu_grant_cnt | ext_grant_cnt | stall_cycle_cnt), 64'(0));
`endif
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
  endtask
  task automatic xact(input bit ext, input bit we, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] exp, input string nm);
    int n, wec, rec, adc, stc, oth;
    n = -1; wec = 0; rec = 0; adc = 0; stc = 0; oth = 0;
    @(negedge clk);
    if (ext) begin ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = wd; end
    else begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    for (int i = 0; i < 20; i++) begin
      #1;
      wec += int'(mem_we);
      rec += int'(mem_re);
      adc += int'(mem_addr == a && mem_wdata == wd);
      stc += int'(cpu_stall);
      oth += int'(ext ? cpu_ack : ext_ack);
      if (ext ? ext_ack : cpu_ack) begin n = i; break; end
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(n), 64'(LAT + 1));
    chk({nm, " rdata"}, ext ? ext_rdata : cpu_rdata, exp);
    chk({nm, " we_pulses"}, 64'(wec), 64'(we));
    chk({nm, " re_cycles"}, 64'(rec), we ? 64'(0) : 64'(LAT));
    chk({nm, " addr_cycles"}, 64'(adc), 64'(LAT));
    chk({nm, " stall_cycles"}, 64'(stc), ext ? 64'(0) : 64'(LAT + 1));
    chk({nm, " other_ack"}, 64'(oth), 64'(0));
    @(negedge clk);
    cpu_req = 1'b0;
    ext_req = 1'b0;
  endtask
  initial begin
    int order[$];
    int cat, eat, c, free_at, streak, cdue, edue;
    bit cwe, ewe, cpend, epend, cseen, eseen, e, w;
    logic [63:0] cexp, eexp, crd, erd, a, wd, rv;
    emem[64'h10] = 64'hDEAD;
    emem[TOP] = 64'hFFFF_0000_1234_5678;
    tbl[0] = '{0, 0, 64'h10, 64'h1111, 64'hDEAD};
    tbl[1] = '{0, 1, 64'h20, 64'h55, 64'hDEAD};
    tbl[2] = '{0, 0, 64'h20, 64'h2222, 64'h55};
    tbl[3] = '{1, 0, 64'h10, 64'h3333, 64'hDEAD};
    tbl[4] = '{1, 1, 64'h30, 64'hCAFE, 64'hDEAD};
    tbl[5] = '{0, 0, 64'h30, 64'h4444, 64'hCAFE};
    tbl[6] = '{1, 0, 64'h20, 64'h5555, 64'h55};
    tbl[7] = '{0, 0, TOP, 64'h6666, 64'hFFFF_0000_1234_5678};
    tbl[8] = '{0, 1, TOP, '1, 64'hFFFF_0000_1234_5678};
    tbl[9] = '{1, 0, TOP, 64'h7777, '1};
    do_reset(1'b1);
    for (int i = 0; i < 10; i++)
      xact(tbl[i].ext, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) xact(1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD, $sformatf("perf_rd%0d", i));
`ifdef DMEM_ARB_PERF_EN
    #1;
    chk("perf_cpu_grants", 64'(cpu_grant_cnt), 64'(3));
    chk("perf_ext_grants", 64'(ext_grant_cnt), 64'(0));
    chk("perf_stall_cycles", 64'(stall_cycle_cnt), 64'(3 * (LAT + 1)));
`endif
    do_reset(1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h20;
    for (int i = 0; i < 200 && order.size() < 6; i++) begin
      #1;
      chk("contend_ack_excl", 64'(cpu_ack & ext_ack), 64'(0));
      if (cpu_ack) order.push_back(0);
      if (ext_ack) order.push_back(1);
      @(negedge clk);
    end
    cpu_req = 1'b0;
    ext_req = 1'b0;
    for (int j = 0; j < 6; j++)
      chk($sformatf("contend_order%0d", j), 64'(j < order.size() ? order[j] : 2), 64'(j == 4));
    chk("contend_ext_rdata", ext_rdata, 64'h55);
    do_reset(1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    cat = -1; eat = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h30; end
      #1;
      if (cpu_ack) cat = i;
      if (ext_ack) eat = i;
      chk("pend_ack_excl", 64'(cpu_ack & ext_ack), 64'(0));
      @(negedge clk);
      if (cat >= 0) cpu_req = 1'b0;
      if (eat >= 0) ext_req = 1'b0;
    end
    chk("pend_cpu_ack_cycle", 64'(cat), 64'(LAT + 1));
    chk("pend_ext_ack_cycle", 64'(eat), 64'(2 * LAT + 3));
    chk("pend_ext_rdata", ext_rdata, 64'hCAFE);
    chk("pend_cpu_rdata", cpu_rdata, 64'hDEAD);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_mem_we_re", 64'({mem_we, mem_re}), 64'(0));
    chk("midrst_mem_addr", mem_addr, 64'(0));
    chk("midrst_cpu_rdata", cpu_rdata, 64'(0));
    cat = 0;
    for (int i = 0; i < 8; i++) begin
      cat += int'(cpu_ack | ext_ack);
      @(negedge clk);
      #1;
    end
    chk("midrst_no_ack", 64'(cat), 64'(0));
    xact(1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD, "midrst_after");
    do_reset(1'b0);
    emem.delete();
    mmem.delete();
    free_at = 0; streak = 0; cdue = -1; edue = -1;
    cwe = 0; ewe = 0; cpend = 0; epend = 0; cseen = 0; eseen = 0;
    cexp = '0; eexp = '0; crd = '0; erd = '0;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cseen) cpend = 1'b0;
      if (eseen) epend = 1'b0;
      if (!cpend && $urandom_range(0, 2) == 0) begin
        cpend = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 64'($urandom_range(0, 7)) << 3;
        cpu_wdata = {$urandom, $urandom};
      end
      if (!epend && $urandom_range(0, 3) == 0) begin
        epend = 1'b1;
        ext_we = 1'($urandom_range(0, 1));
        ext_addr = 64'($urandom_range(0, 7)) << 3;
        ext_wdata = {$urandom, $urandom};
      end
      cpu_req = cpend;
      ext_req = epend;
      #1;
      cseen = cpu_ack;
      eseen = ext_ack;
      if (c == cdue && !cwe) crd = cexp;
      if (c == edue && !ewe) erd = eexp;
      chk("rnd_cpu_ack", 64'(cpu_ack), 64'(c == cdue));
      chk("rnd_ext_ack", 64'(ext_ack), 64'(c == edue));
      chk("rnd_cpu_rdata", cpu_rdata, crd);
      chk("rnd_ext_rdata", ext_rdata, erd);
      chk("rnd_cpu_stall", 64'(cpu_stall), 64'(cpu_req && c != cdue));
      chk("rnd_we_and_re", 64'(mem_we & mem_re), 64'(0));
      if (c >= free_at) begin
        if (cpu_req || ext_req) begin
          e = ext_req && (!cpu_req || streak == SMAX);
          a = e ? ext_addr : cpu_addr;
          wd = e ? ext_wdata : cpu_wdata;
          w = e ? ext_we : cpu_we;
          streak = e ? 0 : (ext_req ? (streak < SMAX ? streak + 1 : SMAX) : 0);
          rv = mmem.exists(a) ? mmem[a] : dflt(a);
          if (w) mmem[a] = wd;
          if (e) begin edue = c + LAT + 1; ewe = w; eexp = rv; end
          else begin cdue = c + LAT + 1; cwe = w; cexp = rv; end
          free_at = c + LAT + 2;
        end else begin
          streak = 0;
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
